pop_count_enumerator: RTL and testbench

- Inverse companion to the 16-bit population counter: given a target count k, emits every WIDTH-bit word whose popcount equals k, in strictly ascending numeric order, one word per accepted handshake.
- Used to generate exhaustive stimulus and constant tables for popcount datapaths, and for combination enumeration in test hardware.
- Next word is computed with the lowest-set-bit / carry / renormalise step (Gosper's method), using shifts only, no divider.

---
 rtl/pop_count_enumerator.sv | 123 ++++++++++++
 tb/tb_pop_count_enumerator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pop_count_enumerator.sv
// Enumerates every WIDTH-bit word with popcount k in ascending order, one per
// accepted valid/ready handshake, stepping with Gosper's next-combination rule.
module pop_count_enumerator #(
   parameter int WIDTH = 16,
   parameter int CW    = 5,
   parameter int IW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CW-1:0]    k,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic [IW-1:0]    out_index,
   output logic             done,
   output logic             err
);

   localparam logic [0:0]      S_IDLE  = 1'b0;
   localparam logic [0:0]      S_EMIT  = 1'b1;
   localparam logic [CW-1:0]   WIDTH_C = CW'(WIDTH);
   localparam logic [WIDTH:0]  ONE_C   = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [IW-1:0]   IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [IW-1:0]    index_q, index_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   function automatic logic [CW-1:0] trail_zeros(input logic [WIDTH:0] c);
      logic [CW-1:0] n;
      n = {CW{1'b0}};
      for (int i = WIDTH; i >= 0; i--) begin
         if (c[i]) begin
            n = CW'(i);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // c isolates the lowest set bit; the carry ripples the low run of ones up
   // and the displaced ones are re-packed at the bottom by the double shift.
   function automatic logic [WIDTH-1:0] gosper_next(input logic [WIDTH-1:0] x);
      logic [WIDTH:0] xe, c, r;
      xe = {1'b0, x};
      c  = xe & (~xe + ONE_C);
      r  = xe + c;
      return WIDTH'(r | (((r ^ xe) >> 2) >> trail_zeros(c)));
   endfunction

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      last_d  = last_q;
      index_d = index_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (k > WIDTH_C) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_EMIT;
                  word_d  = WIDTH'((ONE_C << k) - ONE_C);
                  last_d  = WIDTH'(~((ONE_C << (WIDTH_C - k)) - ONE_C));
                  index_d = {IW{1'b0}};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (word_q == last_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  word_d  = gosper_next(word_q);
                  index_d = index_q + IDX_ONE;
               end
            end else begin
               state_d = S_EMIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         word_q  <= {WIDTH{1'b0}};
         last_q  <= {WIDTH{1'b0}};
         index_q <= {IW{1'b0}};
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         last_q  <= last_d;
         index_q <= index_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy      = (state_q == S_EMIT);
   assign out_valid = (state_q == S_EMIT);
   assign out_word  = word_q;
   assign out_index = index_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pop_count_enumerator.sv
// Directed bench for pop_count_enumerator: per-run sequence checks plus
// hand-computed first/last words and word counts.
module tb_pop_count_enumerator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  k;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_word;
   logic [15:0] out_index;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;
   logic [15:0] words[$];

   pop_count_enumerator #(.WIDTH(16), .CW(5), .IW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k         (k),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_index (out_index),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int kv);
      start = 1'b1;
      k     = 5'(kv);
      step();
      start = 1'b0;
   endtask

   // Consume a run, checking index, popcount, ordering and stall stability.
   task automatic run_stream(input int kv, input bit rnd, input int budget);
      int          cyc;
      bit          stalled;
      logic [15:0] pw;
      logic [15:0] pi;
      cyc     = 0;
      stalled = 1'b0;
      pw      = 16'h0000;
      pi      = 16'h0000;
      words.delete();
      while (out_valid === 1'b1 && cyc < budget) begin
         if (stalled) begin
            chk("stall_word", out_word, pw);
            chk("stall_index", out_index, pi);
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_ready) begin
            chk("index", out_index, words.size());
            chk("popcount", $countones(out_word), kv);
            if (words.size() > 0) chk("ascending", out_word > words[$], 1);
            words.push_back(out_word);
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            pw      = out_word;
            pi      = out_index;
         end
         step();
         cyc++;
      end
      out_ready = 1'b1;
      chk("run_end_valid", out_valid, 0);
      chk("run_end_done", done, 1);
      chk("run_end_busy", busy, 0);
      step();
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      logic [15:0] k2_first[5];
      int guard;
      k2_first[0] = 16'h0003;
      k2_first[1] = 16'h0005;
      k2_first[2] = 16'h0006;
      k2_first[3] = 16'h0009;
      k2_first[4] = 16'h000A;

      rst       = 1'b1;
      start     = 1'b0;
      k         = 5'd0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_word", out_word, 0);
      chk("rst_index", out_index, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      step();

      // k=0: a single zero word
      out_ready = 1'b1;
      do_start(0);
      chk("k0_valid", out_valid, 1);
      chk("k0_busy", busy, 1);
      chk("k0_word", out_word, 16'h0000);
      run_stream(0, 1'b0, 10);
      chk("k0_count", words.size(), 1);

      // k=1: walking one
      do_start(1);
      run_stream(1, 1'b0, 40);
      chk("k1_count", words.size(), 16);
      for (int i = 0; i < 16 && i < words.size(); i++) chk("k1_word", words[i], 32'h1 << i);

      // k=2
      do_start(2);
      run_stream(2, 1'b0, 200);
      chk("k2_count", words.size(), 120);
      for (int i = 0; i < 5 && i < words.size(); i++) chk("k2_first", words[i], k2_first[i]);
      if (words.size() == 120) chk("k2_last", words[119], 16'hC000);
      else chk("k2_last_missing", words.size(), 120);

      // k=8 with random back-pressure
      do_start(8);
      chk("k8_first_word", out_word, 16'h00FF);
      run_stream(8, 1'b1, 60000);
      chk("k8_count", words.size(), 12870);
      chk("k8_last", words[$], 16'hFF00);

      // k=16: a single all-ones word
      do_start(16);
      run_stream(16, 1'b0, 10);
      chk("k16_count", words.size(), 1);
      chk("k16_word", words[0], 16'hFFFF);

      // k=17: out of range
      do_start(17);
      chk("k17_err", err, 1);
      chk("k17_valid", out_valid, 0);
      chk("k17_busy", busy, 0);
      step();
      chk("k17_err_pulse", err, 0);
      chk("k17_done", done, 0);
      chk("k17_valid2", out_valid, 0);

      // k=3 with a stray start and a k change mid-run
      do_start(3);
      out_ready = 1'b0;
      start     = 1'b1;
      k         = 5'd5;
      step();
      start = 1'b0;
      k     = 5'd0;
      chk("k3_restart_word", out_word, 16'h0007);
      chk("k3_restart_index", out_index, 0);
      chk("k3_restart_err", err, 0);
      run_stream(3, 1'b0, 1000);
      chk("k3_count", words.size(), 560);
      chk("k3_last", words[$], 16'hE000);

      // k=4 interrupted by async reset at index 50
      do_start(4);
      out_ready = 1'b1;
      guard = 0;
      while (out_index !== 16'd50 && guard < 200) begin
         step();
         guard++;
      end
      chk("k4_reach50", out_index, 50);
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_word", out_word, 0);
      chk("async_index", out_index, 0);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      do_start(4);
      chk("k4_fresh_word", out_word, 16'h000F);
      chk("k4_fresh_index", out_index, 0);
      run_stream(4, 1'b0, 3000);
      chk("k4_count", words.size(), 1820);
      chk("k4_last", words[$], 16'hF000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
